regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 2, entries per source queue; power of two, >= 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 a_valid  in  1  source A (ALU writeback) offers an entry.
REQ-005 a_ready  out  1  A queue can accept; transfer when a_valid & a_ready at rising edge.
REQ-006 a_addr  in  5  A destination register.
REQ-007 a_data  in  32  A write data.
REQ-008 b_valid, b_ready, b_addr, b_data  in/out/in/in  1/1/5/32  source B (load/multicycle unit); same rules as A.
REQ-009 we  out  1  register-file write enable.
REQ-010 waddr  out  5  register-file write address.
REQ-011 wdata  out  32  register-file write data.
REQ-012 pending  out  32  bit r = 1 while a write to register r is queued or is on the write port.
REQ-013 q_addr1, q_addr2  in  5  hazard query addresses.
REQ-014 q_hit1, q_hit2  out  1  combinational: pending[q_addrN].

Function
REQ-015 The block SHALL hold one FIFO_DEPTH-entry FIFO per source, with {addr, data} per entry and a per-source count from 0 to FIFO_DEPTH.
REQ-016 x_ready SHALL be 1 iff the registered count < FIFO_DEPTH; a same-cycle pop SHALL NOT raise ready (no full-queue bypass).
REQ-017 Each cycle the arbiter SHALL grant at most one non-empty queue head and pop it at the next edge.
REQ-018 With both queues non-empty, the grant SHALL go to the queue named by the round-robin pointer rp (A or B).
REQ-019 With one queue non-empty, the grant SHALL go to that queue.
REQ-020 After any grant, rp SHALL point to the other source; with no grant, rp SHALL hold.
REQ-021 The output stage SHALL be registered: a head granted in the cycle ending at edge E SHALL appear on waddr/wdata at edge E.
REQ-022 we SHALL be 1 for exactly one cycle per granted entry whose addr != 0.
REQ-023 An entry with addr 0 SHALL be popped normally with we = 0; waddr and wdata SHALL still load.
REQ-024 With no grant, we SHALL be 0; waddr and wdata SHALL hold their values.
REQ-025 Latency: entry accepted at edge N -> we = 1 in the cycle after edge N+1 (best case); the register file commits at edge N+2.
REQ-026 Per-source order SHALL be preserved; no entry SHALL be lost or duplicated.
REQ-027 Sustained throughput SHALL be one write per cycle while any queue is non-empty.
REQ-028 Counts SHALL update as count + push - pop; simultaneous push and pop at count 1..FIFO_DEPTH-1 leaves count unchanged.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 pending SHALL be the OR of decoded addr over valid entries in both queues and the output stage when we = 1.
REQ-031 pending bit 0 SHALL always be 0.
REQ-032 pending SHALL be driven from registered state only.

Reset
REQ-033 While rst = 1: we = 0, waddr = 0, wdata = 0, both counts and pointers = 0, rp = A, pending = 0, a_ready = b_ready = 0.
REQ-034 Reset SHALL take effect without a clock edge.
REQ-035 Entries queued when reset asserts SHALL be discarded and never written.
REQ-036 At the first edge after rst deasserts, a_ready = b_ready = 1.

Verification
REQ-037 Single write: A pushes addr 5, data 0x00001234 at edge N -> pending[5] = 1 from N. After edge N+1: we = 1, waddr = 5, wdata = 0x00001234 for one cycle. pending[5] = 0 after N+2.
REQ-038 Contention: A and B valid every cycle, addrs 1..8 / 9..16, after reset -> write order 1,9,2,10,...; we continuous; each x_ready drops when its count reaches 2; all 16 writes occur, in order per source.
REQ-039 Zero address: A pushes addr 0, data 0xFFFFFFFF -> pop occurs, we stays 0, pending stays 0, a_ready stays 1.
REQ-040 Hazard query: B entry addr 7 queued, q_addr1 = 7, q_addr2 = 8 -> q_hit1 = 1, q_hit2 = 0 in the same cycle.
REQ-041 Mid-operation reset: both queues full, rst pulsed between edges -> we = 0 and pending = 0 immediately. After release, no queued entry is ever written and the first grant with both sources valid goes to A.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Writeback source handshake bundle: two independent valid/ready producers (A and B),
// each offering a destination register address and write data.
interface regfile_wb_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file writeback arbiter: per-source FIFOs, round-robin grant,
// registered write port and a pending-write scoreboard for hazard queries.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  src,
  output logic         we,
  output logic [4:0]   waddr,
  output logic [31:0]  wdata,
  output logic [31:0]  pending,
  input  logic [4:0]   q_addr1,
  input  logic [4:0]   q_addr2,
  output logic         q_hit1,
  output logic         q_hit2
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  entry_t        mem [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [CW-1:0] count [2];
  src_e          rp;

  entry_t        in_entry [2];
  entry_t        head [2];
  entry_t        out_entry;
  logic [1:0]    ready;
  logic [1:0]    push;
  logic [1:0]    non_empty;
  logic [1:0]    grant;

  assign in_entry[0] = {src.a_addr, src.a_data};
  assign in_entry[1] = {src.b_addr, src.b_data};

  // Ready looks only at the registered count, so a pop in the same cycle never frees a slot early.
  assign ready[0] = !rst && (count[0] < CW'(FIFO_DEPTH));
  assign ready[1] = !rst && (count[1] < CW'(FIFO_DEPTH));
  assign src.a_ready = ready[0];
  assign src.b_ready = ready[1];

  assign push[0] = src.a_valid & ready[0];
  assign push[1] = src.b_valid & ready[1];

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    grant = '0;
    for (int s = 0; s < 2; s++) begin
      non_empty[s] = (count[s] != '0);
      head[s]      = mem[s][rd_ptr[s]];
    end
    if (non_empty[0] && (!non_empty[1] || rp == SRC_A)) grant[0] = 1'b1;
    else if (non_empty[1])                               grant[1] = 1'b1;
    out_entry = grant[0] ? head[0] : head[1];
  end

  // NOTE: queue storage has no reset; an entry is only meaningful below its queue's count, which is reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        count[s]  <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
      end
      rp    <= SRC_A;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s])  wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (grant[s]) rd_ptr[s] <= rd_ptr[s] + PW'(1);
        count[s] <= count[s] + CW'(push[s]) - CW'(grant[s]);
      end
      if (|grant) begin
        rp    <= grant[0] ? SRC_B : SRC_A;
        waddr <= out_entry.addr;
        wdata <= out_entry.data;
        we    <= (out_entry.addr != 5'd0);
      end else begin
        we <= 1'b0;
      end
    end
  end

  // Scoreboard built purely from registered state: live queue entries plus the write port.
  always_comb begin
    pending = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) < count[s]) pending[mem[s][rd_ptr[s] + PW'(i)].addr] = 1'b1;
      end
    end
    if (we) pending[waddr] = 1'b1;
    pending[0] = 1'b0;
  end

  assign q_hit1 = pending[q_addr1];
  assign q_hit2 = pending[q_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and randomized traffic.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pending;
  logic [4:0]  q_addr1 = '0;
  logic [4:0]  q_addr2 = '0;
  logic        q_hit1;
  logic        q_hit2;

  regfile_wb_if ifc ();

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .src     (ifc),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .pending (pending),
    .q_addr1 (q_addr1),
    .q_addr2 (q_addr2),
    .q_hit1  (q_hit1),
    .q_hit2  (q_hit2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues, a round-robin flag and the expected write-port contents.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        qa[$];
  ent_t        qb[$];
  bit          rp_b    = 1'b0;
  logic        m_we    = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    foreach (qa[i]) p[qa[i].addr] = 1'b1;
    foreach (qb[i]) p[qb[i].addr] = 1'b1;
    if (m_we) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  initial begin : model
    bit   pa, pb, ga, gb;
    ent_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        qa.delete();
        qb.delete();
        rp_b    = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
      end else begin
        pa = ifc.a_valid && (qa.size() < DEPTH);
        pb = ifc.b_valid && (qb.size() < DEPTH);
        ga = (qa.size() != 0) && ((qb.size() == 0) || !rp_b);
        gb = !ga && (qb.size() != 0);
        m_we = 1'b0;
        if (ga) begin
          e = qa.pop_front();
          rp_b = 1'b1;
        end else if (gb) begin
          e = qb.pop_front();
          rp_b = 1'b0;
        end
        if (ga || gb) begin
          m_we    = (e.addr != 5'd0);
          m_waddr = e.addr;
          m_wdata = e.data;
        end
        if (pa) qa.push_back('{addr: ifc.a_addr, data: ifc.a_data});
        if (pb) qb.push_back('{addr: ifc.b_addr, data: ifc.b_data});
      end
    end
  end

  // Compare process plus write log for ordering scenarios.
  bit          log_en = 1'b0;
  int          wlog[$];
  int          cyc_cnt = 0;
  int          first_we = -1;
  int          last_we = -1;
  logic [31:0] ep;

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc_cnt++;
      ep = exp_pending();
      check("we",      we,          m_we);
      check("waddr",   waddr,       m_waddr);
      check("wdata",   wdata,       m_wdata);
      check("pending", pending,     ep);
      check("a_ready", ifc.a_ready, !rst && (qa.size() < DEPTH));
      check("b_ready", ifc.b_ready, !rst && (qb.size() < DEPTH));
      check("q_hit1",  q_hit1,      ep[q_addr1]);
      check("q_hit2",  q_hit2,      ep[q_addr2]);
      if (log_en && we) begin
        wlog.push_back(int'(waddr));
        if (first_we < 0) first_we = cyc_cnt;
        last_we = cyc_cnt;
      end
    end
  end

  int exp_order [16] = '{1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15, 8, 16};

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    ifc.a_valid = av;
    ifc.a_addr  = aa;
    ifc.a_data  = ad;
    ifc.b_valid = bv;
    ifc.b_addr  = ba;
    ifc.b_data  = bd;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin : stimulus
    int ai, bi;
    bit ra, rb, done;
    drive_idle();
    #1 rst = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_we",      we,          1'b0);
    check("rst_waddr",   waddr,       5'd0);
    check("rst_wdata",   wdata,       32'd0);
    check("rst_pending", pending,     32'd0);
    check("rst_a_ready", ifc.a_ready, 1'b0);
    check("rst_b_ready", ifc.b_ready, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_a_ready", ifc.a_ready, 1'b1);
    check("post_rst_b_ready", ifc.b_ready, 1'b1);

    // Single write with best-case latency
    drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, '0, '0);
    step();
    drive_idle();
    check("single_pend_n",  pending[5], 1'b1);
    check("single_we_n",    we,         1'b0);
    step();
    check("single_we",      we,         1'b1);
    check("single_waddr",   waddr,      5'd5);
    check("single_wdata",   wdata,      32'h0000_1234);
    check("model_we_pin",   m_we,       1'b1);
    step();
    check("single_we_off",  we,         1'b0);
    check("single_pend_off", pending,   32'd0);

    // Zero destination address
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
    step();
    drive_idle();
    check("zero_pending", pending,     32'd0);
    check("zero_a_ready", ifc.a_ready, 1'b1);
    step();
    check("zero_we",      we,          1'b0);
    check("zero_waddr",   waddr,       5'd0);
    check("zero_wdata",   wdata,       32'hFFFF_FFFF);

    // Hazard query
    q_addr1 = 5'd7;
    q_addr2 = 5'd8;
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hCAFE_0007);
    step();
    drive_idle();
    #1;
    check("hazard_hit1", q_hit1, 1'b1);
    check("hazard_hit2", q_hit2, 1'b0);
    repeat (3) step();

    // Contention after reset: strict alternation, continuous writes
    rst = 1'b1;
    #1 rst = 1'b0;
    wlog.delete();
    first_we = -1;
    last_we  = -1;
    log_en   = 1'b1;
    ai = 1;
    bi = 9;
    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      drive(ai <= 8, ai[4:0], $urandom(), bi <= 16, bi[4:0], $urandom());
      @(negedge clk);
      ra = ifc.a_ready;
      rb = ifc.b_ready;
      step();
      if (ifc.a_valid && ra) ai++;
      if (ifc.b_valid && rb) bi++;
      done = (ai > 8) && (bi > 16);
    end
    check("cont_done", done, 1'b1);
    drive_idle();
    repeat (5) step();
    log_en = 1'b0;
    check("cont_count", wlog.size(), 16);
    check("cont_span",  last_we - first_we + 1, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < wlog.size()) check("cont_order", wlog[i], exp_order[i]);
    end

    // Mid-operation reset with loaded queues
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(24 + i), $urandom(), 1'b1, 5'(28 + i), $urandom());
      step();
    end
    drive_idle();
    check("midrst_pend_before", pending != 32'd0, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_we",      we,      1'b0);
    check("midrst_pending", pending, 32'd0);
    #1 rst = 1'b0;
    wlog.delete();
    log_en = 1'b1;
    drive(1'b1, 5'd20, 32'hA000_0020, 1'b1, 5'd21, 32'hB000_0021);
    step();
    drive_idle();
    repeat (5) step();
    log_en = 1'b0;
    check("midrst_count", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      check("midrst_first",  wlog[0], 20);
      check("midrst_second", wlog[1], 21);
    end

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom(),
            $urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom());
      q_addr1 = 5'($urandom_range(0, 31));
      q_addr2 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end
    drive_idle();
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
